// File: rtl/mult_div_iter.sv
// mult_div_iter -- iterative multiply / divide unit, one bit per cycle.
//
// Multiply uses shift-add. Divide uses restoring shift-subtract. Both work on
// unsigned magnitudes. The sign correction is applied in a single FIX cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   i_start      begin an operation (accepted in IDLE or DONE)
//   i_op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_operand_1  multiplicand / dividend
//   i_operand_2  multiplier / divisor
//   i_flush      synchronous cancel, wins over i_start
//   o_busy       high while in CALC or FIX
//   o_done       one-cycle completion pulse (DONE state)
//   o_div_zero   last completed op was a divide by zero
//   o_result     {hi, lo}: product, or {remainder, quotient}
module mult_div_iter #(
   parameter int DATA_WIDTH = 32,
   parameter bit SKIP_DIV0  = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_start,
   input  logic [1:0]                i_op,
   input  logic [DATA_WIDTH-1:0]     i_operand_1,
   input  logic [DATA_WIDTH-1:0]     i_operand_2,
   input  logic                      i_flush,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_div_zero,
   output logic [2*DATA_WIDTH-1:0]   o_result
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_op;
   logic          r_neg1;     // operand_1 was negative (signed ops only)
   logic          r_neg2;     // operand_2 was negative (signed ops only)
   logic [W-1:0]  r_hi;       // product high half / partial remainder
   logic [W-1:0]  r_lo;       // multiplier bits / dividend-then-quotient
   logic [W-1:0]  r_b;        // multiplicand / divisor magnitude

   // ---------------- start-time operand conversion ----------------
   logic          w_signed_in;
   logic          w_neg1_in;
   logic          w_neg2_in;
   logic [W-1:0]  w_mag1;
   logic [W-1:0]  w_mag2;
   logic          w_div0_skip;

   assign w_signed_in = ~i_op[0];
   assign w_neg1_in   = w_signed_in & i_operand_1[W-1];
   assign w_neg2_in   = w_signed_in & i_operand_2[W-1];
   // W-bit unsigned negation, so the most-negative value becomes 2^(W-1).
   assign w_mag1      = w_neg1_in ? (~i_operand_1 + 1'b1) : i_operand_1;
   assign w_mag2      = w_neg2_in ? (~i_operand_2 + 1'b1) : i_operand_2;
   assign w_div0_skip = SKIP_DIV0 && i_op[1] && (i_operand_2 == '0);

   // ---------------- multiply step: add then shift right ----------------
   logic [W:0]    w_msum;
   logic [W-1:0]  w_mul_hi;
   logic [W-1:0]  w_mul_lo;

   assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
   assign w_mul_hi = w_msum[W:1];
   assign w_mul_lo = {w_msum[0], r_lo[W-1:1]};

   // ---------------- divide step: shift left, trial subtract ----------------
   logic [W:0]    w_shift;    // partial remainder with next dividend bit
   logic [W+1:0]  w_diff;
   logic          w_ge;
   logic [W-1:0]  w_div_hi;
   logic [W-1:0]  w_div_lo;

   assign w_shift  = {r_hi, r_lo[W-1]};
   assign w_diff   = {1'b0, w_shift} - {2'b00, r_b};
   assign w_ge     = ~w_diff[W+1];
   // Restore (keep the shifted value) when the trial subtract goes negative.
   assign w_div_hi = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
   assign w_div_lo = {r_lo[W-2:0], w_ge};

   // ---------------- FIX: sign correction ----------------
   logic [W-1:0]  w_fix_hi;
   logic [W-1:0]  w_fix_lo;

   always_comb begin
      w_fix_hi = r_hi;
      w_fix_lo = r_lo;
      case (r_op)
         2'b00: begin
            if (r_neg1 ^ r_neg2)
               {w_fix_hi, w_fix_lo} = ~{r_hi, r_lo} + 1'b1;
         end
         2'b10: begin
            // Remainder follows the dividend sign; quotient the sign product.
            // Most-negative / -1 wraps naturally to most-negative, remainder 0.
            if (r_neg1 ^ r_neg2) w_fix_lo = ~r_lo + 1'b1;
            if (r_neg1)          w_fix_hi = ~r_hi + 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------- state machine ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_op       <= 2'b00;
         r_neg1     <= 1'b0;
         r_neg2     <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_b        <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_div_zero <= 1'b0;
         o_result   <= '0;
      end else if (i_flush) begin
         // Cancel: result and div_zero keep their previous values.
         r_state <= S_IDLE;
         r_cnt   <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
               if (i_start) begin
                  if (w_div0_skip) begin
                     r_state    <= S_DONE;
                     o_done     <= 1'b1;
                     o_result   <= {i_operand_1, {W{1'b1}}};
                     o_div_zero <= 1'b1;
                  end else begin
                     r_state    <= S_CALC;
                     o_busy     <= 1'b1;
                     r_cnt      <= '0;
                     r_op       <= i_op;
                     r_neg1     <= w_neg1_in;
                     r_neg2     <= w_neg2_in;
                     r_hi       <= '0;
                     // Multiply: lo holds multiplier, b the multiplicand.
                     // Divide:   lo holds dividend,   b the divisor.
                     r_lo       <= i_op[1] ? w_mag1 : w_mag2;
                     r_b        <= i_op[1] ? w_mag2 : w_mag1;
                     o_div_zero <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               r_hi  <= r_op[1] ? w_div_hi : w_mul_hi;
               r_lo  <= r_op[1] ? w_div_lo : w_mul_lo;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(W-1))
                  r_state <= S_FIX;
            end
            S_FIX: begin
               r_state  <= S_DONE;
               o_busy   <= 1'b0;
               o_done   <= 1'b1;
               o_result <= {w_fix_hi, w_fix_lo};
            end
            default: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_iter.sv
// Self-checking bench for mult_div_iter (W=32, SKIP_DIV0=1).
// The reference model uses plain 64-bit integer arithmetic.
module tb_mult_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_1;
   logic [31:0] operand_2;
   logic        flush;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [63:0] result;

   int n_cmp = 0;
   int n_err = 0;

   mult_div_iter #(.DATA_WIDTH(32), .SKIP_DIV0(1'b1)) dut (
      .clk(clk), .rst(rst), .i_start(start), .i_op(op),
      .i_operand_1(operand_1), .i_operand_2(operand_2), .i_flush(flush),
      .o_busy(busy), .o_done(done), .o_div_zero(div_zero), .o_result(result)
   );

   always #5 clk = ~clk;

   // Reference model: arithmetic on sign-extended / zero-extended 64-bit ints.
   function automatic void model(input logic [1:0] mop, input logic [31:0] a,
                                 input logic [31:0] b, output logic [63:0] res,
                                 output logic dz);
      longint sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      dz  = 1'b0;
      res = '0;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      case (mop)
         2'b00: res = 64'(sa * sb);
         2'b01: res = ua * ub;
         default: begin
            if (b == 32'd0) begin
               res = {a, 32'hFFFF_FFFF};
               dz  = 1'b1;
            end else if (mop == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end else begin
               uq = ua / ub;
               ur = ua % ub;
               res = {ur[31:0], uq[31:0]};
            end
         end
      endcase
   endfunction

   // Issue one op and wait for done. lat = rising edges after the accepting edge.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output logic [63:0] res, output logic dz);
      @(negedge clk);
      start = 1'b1; op = o; operand_1 = a; operand_2 = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result;
      dz  = div_zero;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
      operand_1 = '0; operand_2 = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, div_zero} !== 3'b000 || result !== 64'd0) begin
         n_err++;
         $display("FAIL reset: busy=%b done=%b dz=%b result=%h, want 0", busy, done, div_zero, result);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [1:0]  ops[5]  = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b10};
      logic [31:0] as[5]   = '{32'hFFFF_FFFE, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
      logic [31:0] bs[5]   = '{32'd3, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
      logic [63:0] exp[5]  = '{64'hFFFF_FFFF_FFFF_FFFA, {32'd2, 32'd14},
                               64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000,
                               {32'd5, 32'hFFFF_FFFF}};
      logic        edz[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int          elat[5] = '{33, 33, 33, 33, 0};
      int lat; logic [63:0] res; logic dz;
      for (int i = 0; i < 5; i++) begin
         do_op(ops[i], as[i], bs[i], lat, res, dz);
         n_cmp++;
         if (res !== exp[i] || dz !== edz[i] || lat != elat[i]) begin
            n_err++;
            $display("FAIL directed%0d: result=%h dz=%b lat=%0d, want %h %b %0d",
                     i, res, dz, lat, exp[i], edz[i], elat[i]);
         end
      end
   endtask

   task automatic test_random();
      int lat, elat; logic [63:0] res, er; logic dz, edz;
      logic [1:0] o; logic [31:0] a, b;
      for (int i = 0; i < 60; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = 32'($urandom_range(1, 20));
            default: ;
         endcase
         model(o, a, b, er, edz);
         elat = (o[1] && b == 32'd0) ? 0 : 33;
         do_op(o, a, b, lat, res, dz);
         n_cmp++;
         if (res !== er || dz !== edz || lat != elat) begin
            n_err++;
            $display("FAIL random%0d op=%0d a=%h b=%h: result=%h dz=%b lat=%0d, want %h %b %0d",
                     i, o, a, b, res, dz, lat, er, edz, elat);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int lat, extra; logic [63:0] res, er; logic dz, edz;
      model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, er, edz);
      @(negedge clk);
      start = 1'b1; op = 2'b01; operand_1 = 32'h1234_5678; operand_2 = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL busy_high: busy=%b, want 1", busy);
      end
      // Hold a different start while busy for 5 edges.
      start = 1'b1; op = 2'b11; operand_1 = 32'd77; operand_2 = 32'd5;
      repeat (5) @(posedge clk);
      #1;
      start = 1'b0;
      lat = 8;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result;
      n_cmp++;
      if (res !== er || lat != 33) begin
         n_err++;
         $display("FAIL busy_ignore: result=%h lat=%0d, want %h 33", res, lat, er);
      end
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_err++;
         $display("FAIL busy_second_done: extra done cycles=%0d, want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [63:0] res, er1, er2; logic dz, edz;
      model(2'b00, 32'hFFFF_FF00, 32'h0000_1234, er1, edz);
      model(2'b10, 32'd1000, 32'hFFFF_FFFD, er2, edz);
      do_op(2'b00, 32'hFFFF_FF00, 32'h0000_1234, lat, res, dz);
      n_cmp++;
      if (res !== er1 || lat != 33) begin
         n_err++;
         $display("FAIL b2b_first: result=%h lat=%0d, want %h 33", res, lat, er1);
      end
      // Now in the DONE cycle: present the next start immediately.
      start = 1'b1; op = 2'b10; operand_1 = 32'd1000; operand_2 = 32'hFFFF_FFFD;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      n_cmp++;
      if (result !== er2 || lat != 33) begin
         n_err++;
         $display("FAIL b2b_second: result=%h lat=%0d, want %h 33", result, lat, er2);
      end
   endtask

   task automatic test_flush();
      int lat, extra; logic [63:0] res, prev; logic dz, edz;
      model(2'b11, 32'd12345, 32'd67, prev, edz);
      do_op(2'b11, 32'd12345, 32'd67, lat, res, dz);
      @(negedge clk);
      start = 1'b1; op = 2'b01; operand_1 = 32'hDEAD_BEEF; operand_2 = 32'h0000_0F0F;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_busy: busy=%b, want 0", busy);
      end
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      n_cmp++;
      if (extra != 0 || result !== prev || div_zero !== 1'b0) begin
         n_err++;
         $display("FAIL flush_hold: done cycles=%0d result=%h dz=%b, want 0 %h 0",
                  extra, result, div_zero, prev);
      end
   endtask

   task automatic test_rst_mid();
      int lat, extra; logic [63:0] res, er; logic dz, edz;
      // Leave a nonzero result behind first.
      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, dz);
      @(negedge clk);
      start = 1'b1; op = 2'b00; operand_1 = 32'd9; operand_2 = 32'd11;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, div_zero} !== 3'b000 || result !== 64'd0) begin
         n_err++;
         $display("FAIL rst_mid: busy=%b done=%b dz=%b result=%h, want 0", busy, done, div_zero, result);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_err++;
         $display("FAIL rst_no_done: done cycles=%0d, want 0", extra);
      end
      model(2'b00, 32'hFFFF_FFF0, 32'd16, er, edz);
      do_op(2'b00, 32'hFFFF_FFF0, 32'd16, lat, res, dz);
      n_cmp++;
      if (res !== er || lat != 33) begin
         n_err++;
         $display("FAIL rst_first_start: result=%h lat=%0d, want %h 33", res, lat, er);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_ignore();
      test_back_to_back();
      test_flush();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mult_div_iter.md
MULT_DIV_ITER -- requirements
Module: mult_div_iter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the operand width W (even, >= 8).
REQ-002 Parameter SKIP_DIV0, default 1, SHALL, when 1, enable single-cycle completion of divide-by-zero.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request to begin an operation; sampled on the clock edge.
REQ-006 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 operand_1  input  W  multiplicand or dividend.
REQ-008 operand_2  input  W  multiplier or divisor.
REQ-009 flush  input  1  synchronous cancel of any in-flight operation.
REQ-010 busy  output  1  high in CALC and FIX.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 div_zero  output  1  divide by zero on the last completed op; held with result.
REQ-013 result  output  2W  {hi, lo}: product hi:lo, or remainder:quotient.

Function
REQ-014 The state machine SHALL have exactly four states: IDLE, CALC, FIX, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL latch op and operands at that edge and enter CALC with iteration counter = 0.
REQ-016 Exception: for DIV/DIVU with operand_2=0 and SKIP_DIV0=1, start SHALL enter DONE directly, setting result={operand_1, all-ones} and div_zero=1.
REQ-017 Without that exception, start SHALL clear div_zero at the accepting edge.
REQ-018 Operand conversion at start: signed ops SHALL convert negative operands to magnitude; sign flags SHALL be stored.
REQ-019 Magnitude arithmetic SHALL be W-bit unsigned, so the most-negative value maps to 2^(W-1).
REQ-020 CALC SHALL process one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-021 CALC SHALL last exactly W cycles, then move to FIX.
REQ-022 With SKIP_DIV0=0, divide by zero SHALL run the full CALC sequence, and the result SHALL be whatever the restoring algorithm yields.
REQ-023 FIX SHALL last one cycle and then move to DONE.
REQ-024 FIX sign rules: MULT SHALL negate the 2W product if operand signs differ.
REQ-025 FIX sign rules: DIV SHALL negate the quotient if operand signs differ, and negate the remainder if the dividend is negative.
REQ-026 Unsigned ops SHALL pass through FIX unchanged.
REQ-027 Latency: done SHALL be high in the cycle following edge E0+W+1, where E0 is the accepting edge (W+1 cycles; 33 for W=32).
REQ-028 done SHALL be 1 only in DONE.
REQ-029 DONE SHALL last one cycle, then return to IDLE, unless start=1, which is accepted per REQ-015 (back-to-back).
REQ-030 result and div_zero SHALL update only on entry to DONE and hold until the next DONE entry.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 flush=1 SHALL force IDLE at the next edge from any state and take priority over start.
REQ-033 After flush, result and div_zero SHALL keep their previous values, and done SHALL not assert for the cancelled op.
REQ-034 Overflow on DIV of most-negative by -1 SHALL wrap: quotient = most-negative, remainder = 0; no flag.
REQ-035 Outputs SHALL be registered; done SHALL not depend combinationally on start.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, counter=0, busy=0, done=0, div_zero=0, result=0, regardless of clk.
REQ-037 Reset asserted mid-CALC SHALL abandon the operation, and no done SHALL follow deassertion.
REQ-038 The first start after rst deassertion SHALL be accepted normally.

Verification
REQ-039 MULT (W=32): start, op=00, 0xFFFFFFFE x 0x00000003 -> done exactly 33 cycles later, result=0xFFFFFFFF_FFFFFFFA.
REQ-040 DIVU: 100 / 7 -> result hi=2, lo=14, div_zero=0.
REQ-041 DIV: -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-042 DIV: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-043 DIV by zero, SKIP_DIV0=1: start, op=10, operand_1=5, operand_2=0 -> done next cycle, result={5, 0xFFFFFFFF}, div_zero=1.
REQ-044 MULTU start, flush at cycle 10 -> IDLE, no done, result unchanged.
REQ-045 Second start held during busy -> ignored.
REQ-046 start during the DONE cycle -> new op accepted; done again W+1 cycles later.
REQ-047 rst pulse mid-CALC between clock edges -> outputs 0 immediately.
